// File: rtl/mmc3_a12_filter_pkg.sv
// Shared definitions for the MMC3 A12 filter: FSM encodings, default
// parameters and save-state slot offsets.
package mmc3_a12_filter_pkg;

  typedef enum logic [1:0] {
    S_HIGH  = 2'd0,
    S_LOW   = 2'd1,
    S_ARMED = 2'd2
  } a12_state_t;

  localparam int DEFAULT_LOW_MIN  = 3;
  localparam int DEFAULT_IDLE_MAX = 255;

  // Bit offsets of the exported fields inside the mapper save-state word.
  localparam int SS_OFF_STATE   = 0;
  localparam int SS_OFF_LOW_CNT = 2;
  localparam int SS_OFF_IDLE    = 6;

  function automatic logic [7:0] pack_save_state(input logic [1:0] state,
                                                 input logic [3:0] low_cnt,
                                                 input logic       idle);
    logic [7:0] word;
    word = '0;
    word[SS_OFF_STATE +: 2]   = state;
    word[SS_OFF_LOW_CNT +: 4] = low_cnt;
    word[SS_OFF_IDLE]         = idle;
    return word;
  endfunction

endpackage

// File: rtl/mmc3_a12_filter_a12_sync2.sv
// Two-flop synchronizer for PPU A12, clocked on the M2 falling edge like
// the rest of the filter.
module a12_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(negedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mmc3_a12_filter.sv
// MMC3 A12 rising-edge filter plus idle detector, updated on M2 falling edge.
// Defining A12_SYNC_EN inserts a two-flop synchronizer ahead of the FSM.
module mmc3_a12_filter
  import mmc3_a12_filter_pkg::*;
#(
  parameter int LOW_MIN  = DEFAULT_LOW_MIN,
  parameter int IDLE_MAX = DEFAULT_IDLE_MAX
) (
  input  logic       m2,
  input  logic       map_rst,
  input  logic       ppu_a12,
  output logic       a12_tick,
  output logic       a12_lvl,
  output logic [3:0] low_cnt,
  output logic       idle,
  output logic [1:0] state_o
);

  localparam logic [3:0] LOW_LIM  = 4'(LOW_MIN);
  localparam logic [7:0] IDLE_LIM = 8'(IDLE_MAX);

  a12_state_t state;
  logic [7:0] idle_cnt;
  logic       sample;
  logic       accept;

`ifdef A12_SYNC_EN
  a12_sync2 u_sync (
    .clk (m2),
    .rst (map_rst),
    .d   (ppu_a12),
    .q   (sample)
  );
`else
  assign sample = ppu_a12;
`endif

  // Only a rise out of a sufficiently long low run counts as a scanline.
  assign accept  = (state == S_ARMED) && sample;
  assign state_o = state;

  always_ff @(negedge m2) begin
    if (map_rst) begin
      state    <= S_LOW;
      low_cnt  <= 4'd0;
      a12_tick <= 1'b0;
      a12_lvl  <= 1'b0;
      idle_cnt <= IDLE_LIM;
      idle     <= 1'b1;
    end else begin
      a12_tick <= accept;
      a12_lvl  <= sample;

      case (state)
        S_HIGH: begin
          if (!sample) begin
            low_cnt <= 4'd1;
            state   <= (LOW_LIM == 4'd1) ? S_ARMED : S_LOW;
          end else begin
            low_cnt <= 4'd0;
          end
        end
        S_LOW: begin
          if (sample) begin
            state   <= S_HIGH;
            low_cnt <= 4'd0;
          end else begin
            low_cnt <= low_cnt + 4'd1;
            if (low_cnt + 4'd1 >= LOW_LIM)
              state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (sample) begin
            state   <= S_HIGH;
            low_cnt <= 4'd0;
          end else begin
            low_cnt <= LOW_LIM;
          end
        end
        default: begin
          state   <= S_LOW;
          low_cnt <= 4'd0;
        end
      endcase

      // idle looks at the pre-update count, hence its one-cycle lag.
      if (accept) begin
        idle_cnt <= 8'd0;
        idle     <= 1'b0;
      end else begin
        idle <= (idle_cnt == IDLE_LIM);
        if (idle_cnt != IDLE_LIM)
          idle_cnt <= idle_cnt + 8'd1;
      end
    end
  end

endmodule
